// File: rtl/spi_host_68k.sv
`default_nettype none
// ==== spi_host_68k: 68000-bus SPI master with TX/RX FIFOs, run-time mode/divider, DTACK and IRQ ====
// ==== Rev 1.0 ====
module spi_host_68k #(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_SS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_n,
  input  logic              as_n,
  input  logic              lds_n,
  input  logic              rw,
  input  logic [1:0]        addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic              dtack_n,
  output logic              irq_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n,
  output logic              dc
);
  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_d;

  logic access, access_q, strobe, wr_stb, rd_stb, dtack_act;
  logic [7:0] ctrl;
  logic [NUM_SS-1:0] ss;
  logic rx_ovf, tx_ovf, busy;
  logic [7:0] status, ss_rd, rd_mux;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0] tx_cnt;
  logic tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_flush;
  logic [7:0]  tx_head;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0] rx_cnt;
  logic rx_full, rx_empty, rx_push_req, rx_push, rx_pop, rx_flush;
  logic [7:0]  rx_head;

  logic [3:0] div_l, dcnt, hc;
  logic cpha_l, bit_edge, lead;
  logic [7:0] tx_sh, rx_sh;

  // Bus side: one strobe per access, DTACK follows a clock later and tracks the strobes.
  assign access  = ~sel_n & ~as_n & ~lds_n;
  assign strobe  = access & ~access_q;
  assign wr_stb  = strobe & ~rw;
  assign rd_stb  = strobe & rw;
  assign data_oe = access & rw;
  assign dtack_n = ~(dtack_act & access);

  assign tx_full  = (tx_cnt == DEPTH_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == DEPTH_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign tx_head  = tx_mem[tx_rp];
  assign rx_head  = rx_mem[rx_rp];

  assign tx_flush    = wr_stb & (addr == 2'd0) & data_in[7];
  assign rx_flush    = wr_stb & (addr == 2'd0) & data_in[6];
  assign tx_push_req = wr_stb & (addr == 2'd1);
  assign tx_pop      = (state == LOAD) & ~tx_empty;
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign rx_pop      = rd_stb & (addr == 2'd1) & ~rx_empty;
  assign rx_push_req = (state == DONE);
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);

  assign busy   = (state != IDLE);
  assign status = {2'b00, tx_ovf, tx_empty, rx_ovf, busy, ~rx_empty, tx_full};
  assign irq_n  = ~((ctrl[7] & ~rx_empty) | rx_ovf);
  assign dc     = ctrl[6];
  assign ss_n   = ~ss;

  always_comb begin
    ss_rd = '0;
    ss_rd[NUM_SS-1:0] = ss;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      2'd0: rd_mux = status;
      2'd1: rd_mux = rx_empty ? 8'h00 : rx_head;
      2'd2: rd_mux = ctrl;
      default: rd_mux = ss_rd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_q  <= 1'b0;
      dtack_act <= 1'b0;
      data_out  <= 8'h00;
      ctrl      <= 8'h30;
      ss        <= '0;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      access_q <= access;
      if (!access)     dtack_act <= 1'b0;
      else if (strobe) dtack_act <= 1'b1;
      if (rd_stb) data_out <= rd_mux;
      if (wr_stb && addr == 2'd2) ctrl <= data_in;
      if (wr_stb && addr == 2'd3) ss <= data_in[NUM_SS-1:0];
      if (wr_stb && addr == 2'd0 && data_in[3]) rx_ovf <= 1'b0;
      if (wr_stb && addr == 2'd0 && data_in[5]) tx_ovf <= 1'b0;
      // A new overflow in the same clock as a clear wins.
      if (rx_push_req && rx_full && !rx_pop) rx_ovf <= 1'b1;
      if (tx_push_req && tx_full && !tx_pop) tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= data_in;
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_rp <= tx_wp; tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_rp <= rx_wp; rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // Shift engine: half-period counter dcnt, edge index hc (even = leading, odd = trailing).
  assign bit_edge = (state == SHIFT) && (dcnt == div_l);
  assign lead     = ~hc[0];

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!tx_empty) state_d = LOAD;
      LOAD:  state_d = tx_empty ? IDLE : SHIFT;
      SHIFT: if (bit_edge && hc == 4'hF) state_d = DONE;
      DONE:  state_d = tx_empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_l  <= 4'h0;
      cpha_l <= 1'b1;
      dcnt   <= 4'h0;
      hc     <= 4'h0;
      tx_sh  <= 8'h00;
      rx_sh  <= 8'h00;
      sclk   <= 1'b1;
      mosi   <= 1'b1;
    end else begin
      case (state)
        LOAD: if (!tx_empty) begin
          tx_sh  <= tx_head;
          div_l  <= ctrl[3:0];
          cpha_l <= ctrl[5];
          sclk   <= ctrl[4];
          dcnt   <= 4'h0;
          hc     <= 4'h0;
          if (!ctrl[5]) mosi <= tx_head[7];
        end
        SHIFT: if (bit_edge) begin
          sclk <= ~sclk;
          dcnt <= 4'h0;
          hc   <= hc + 1'b1;
          if (lead ^ cpha_l) begin
            rx_sh <= {rx_sh[6:0], miso};
          end else begin
            // CPHA=0 already presented bit 7 at LOAD, so its trailing edges present the next bit.
            mosi  <= cpha_l ? tx_sh[7] : tx_sh[6];
            tx_sh <= {tx_sh[6:0], 1'b0};
          end
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
